int_to_fp_seq: RTL

//  Multi-cycle integer-to-single-precision converter (FCVT.S.W/WU/L/LU). Reverse direction of the
//  FPU's FP-to-integer convert path. Sits beside the FPU op mux; results return to FPU writeback
//  via a valid/ready response. Iterative normalisation keeps the block small. Flags exported: NX.

---
 rtl/fp_pkg.sv | 47 ++++
 rtl/int_fp_round.sv | 49 ++++
 rtl/int_to_fp_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP definitions: integer format codes, rounding modes,
// FP32 constants and the int-to-fp FSM state encoding.
package fp_pkg;

    localparam logic [1:0] FMT_W  = 2'b00;
    localparam logic [1:0] FMT_WU = 2'b01;
    localparam logic [1:0] FMT_L  = 2'b10;
    localparam logic [1:0] FMT_LU = 2'b11;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int          FP32_BIAS     = 127;
    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic        sign;
        logic [63:0] mag;
    } int_op_t;

    // Widen the operand to 64 bits and split it into sign/magnitude.
    // The magnitude is unsigned, so -2^63 maps cleanly onto 2^63.
    function automatic int_op_t unpack_int(
        input logic [63:0] data,
        input logic [1:0]  fmt
    );
        logic [63:0] v;
        int_op_t     r;
        unique case (fmt)
            FMT_W:   v = {{32{data[31]}}, data[31:0]};
            FMT_WU:  v = {32'd0, data[31:0]};
            default: v = data;
        endcase
        r.sign = (fmt == FMT_W || fmt == FMT_L) ? v[63] : 1'b0;
        r.mag  = r.sign ? (~v + 64'd1) : v;
        return r;
    endfunction

endpackage

// File: rtl/int_fp_round.sv
// Combinational FP32 packer: normalised magnitude plus shift count in,
// rounded FP32 and inexact flag out.
//   sign, cnt (left shifts applied), mag (normalised), rm -> fp32, nx
module int_fp_round
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [5:0]  cnt,
    input  logic [63:0] mag,
    input  logic [2:0]  rm,
    output logic [31:0] fp32,
    output logic        nx
);

    logic [22:0] mant;
    logic        g;
    logic        s;
    logic        up;
    logic [23:0] mant_inc;
    logic [7:0]  exp_b;
    logic [7:0]  exp_r;

    always_comb begin
        mant = mag[62:40];
        g    = mag[39];
        s    = |mag[38:0];
        up   = 1'b0;
        case (rm)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (g | s);
            RM_RUP:  up = ~sign & (g | s);
            RM_RMM:  up = g;
            default: up = g & (s | mant[0]);
        endcase
        // A carry out of the mantissa leaves the low 23 bits zero,
        // so only the exponent needs bumping.
        mant_inc = {1'b0, mant} + {23'd0, up};
        exp_b    = 8'(FP32_BIAS + 63) - {2'b00, cnt};
        exp_r    = exp_b + {7'd0, mant_inc[23]};
        if (mag == 64'd0) begin
            fp32 = FP32_POS_ZERO;
            nx   = 1'b0;
        end else begin
            fp32 = {sign, exp_r, mant_inc[22:0]};
            nx   = g | s;
        end
    end

endmodule

// File: rtl/int_to_fp_seq.sv
// Iterative integer to FP32 converter (FCVT.S.W/WU/L/LU) with
// valid/ready request and response.
//   in_clk, in_rst       clock, async active-high reset
//   in_req_valid/out_req_ready, in_data, in_fmt, in_rm, in_flush
//   out_rsp_valid/in_rsp_ready, out_data {32'd0,fp32}, out_flag_NX
module int_to_fp_seq
    import fp_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NORM_STEP = 8
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_req_valid,
    output logic            out_req_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [1:0]      in_fmt,
    input  logic [2:0]      in_rm,
    input  logic            in_flush,
    output logic            out_rsp_valid,
    input  logic            in_rsp_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_flag_NX
);

    logic [1:0]      state;
    logic            sign_q;
    logic [XLEN-1:0] mag_q;
    logic [5:0]      cnt_q;
    logic [2:0]      rm_q;
    logic [31:0]     fp32;
    logic            nx;
    logic            accept;
    int_op_t         op;

    assign out_req_ready = (state == ST_IDLE) & ~in_flush;
    assign out_rsp_valid = (state == ST_DONE);
    assign accept        = in_req_valid & out_req_ready;
    assign op            = unpack_int(in_data, in_fmt);

    int_fp_round u_round (
        .sign (sign_q),
        .cnt  (cnt_q),
        .mag  (mag_q),
        .rm   (rm_q),
        .fp32 (fp32),
        .nx   (nx)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state       <= ST_IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= 6'd0;
            rm_q        <= 3'd0;
            out_data    <= '0;
            out_flag_NX <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q <= op.sign;
                        mag_q  <= op.mag;
                        rm_q   <= in_rm;
                        cnt_q  <= 6'd0;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (in_flush) begin
                        state <= ST_IDLE;
                    end else if (mag_q == '0 || mag_q[XLEN-1]) begin
                        state <= ST_ROUND;
                    end else if (mag_q[XLEN-1-:NORM_STEP] == '0) begin
                        // Coarse step clears whole zero bytes quickly.
                        mag_q <= mag_q << NORM_STEP;
                        cnt_q <= cnt_q + 6'(NORM_STEP);
                    end else begin
                        mag_q <= mag_q << 1;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                ST_ROUND: begin
                    if (in_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        out_data    <= {32'd0, fp32};
                        out_flag_NX <= nx;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_rsp_ready || in_flush) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
